// File: rtl/load_store_unit.sv
// Load/store controller for a word-organised data memory. Handles byte, halfword and word
// accesses; sub-word stores are done as read-modify-write because memory writes whole words.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StStore,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] store_word;

    // Misaligned or illegal-size requests never touch memory.
    always_comb begin
        unique case (req_size)
            SizeByte: req_err = 1'b0;
            SizeHalf: req_err = req_addr[0];
            SizeWord: req_err = (req_addr[1:0] != 2'b00);
            default:  req_err = 1'b1;
        endcase
    end

    // Little-endian lane extraction from the word being read.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    rd_byte = ReadData[7:0];
            2'd1:    rd_byte = ReadData[15:8];
            2'd2:    rd_byte = ReadData[23:16];
            default: rd_byte = ReadData[31:24];
        endcase
        rd_half = addr_q[1] ? ReadData[31:16] : ReadData[15:0];
        unique case (size_q)
            SizeByte: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SizeHalf: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default:  load_ext = ReadData;
        endcase
    end

    // Merge the new lane into the word captured during RMW_RD.
    always_comb begin
        store_word = merge_q;
        unique case (size_q)
            SizeByte: begin
                unique case (addr_q[1:0])
                    2'd0:    store_word[7:0]   = wdata_q[7:0];
                    2'd1:    store_word[15:8]  = wdata_q[7:0];
                    2'd2:    store_word[23:16] = wdata_q[7:0];
                    default: store_word[31:24] = wdata_q[7:0];
                endcase
            end
            SizeHalf: begin
                if (addr_q[1]) begin
                    store_word[31:16] = wdata_q[15:0];
                end else begin
                    store_word[15:0] = wdata_q[15:0];
                end
            end
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        error_d  = error_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    error_d  = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_write) begin
                        state_d = StLoad;
                    end else if (req_size == SizeWord) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_ext;
                state_d = StResp;
            end
            StRmwRd: begin
                merge_d = ReadData;
                state_d = StStore;
            end
            StStore: begin
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        MemRead    = (state_q == StLoad) || (state_q == StRmwRd);
        MemWrite   = (state_q == StStore);
        resp_valid = (state_q == StResp);
        Address    = (MemRead || MemWrite) ? {2'b00, addr_q[31:2]} : 32'h0;
        WriteData  = MemWrite ? store_word : 32'h0;
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        resp_error = resp_valid && error_q;
    end

    logic unused_write;
    assign unused_write = write_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the word-organised data memory. It accepts byte, halfword and word load/store requests from the pipeline over a valid/ready handshake and drives MemRead/MemWrite/Address/WriteData. It returns aligned, sign- or zero-extended load data over a valid/ready response channel. Sub-word stores use an internal read-modify-write sequence, because the memory writes only whole 32-bit words.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or illegal-size request; no memory access performed
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe; write occurs on rising clk edge while high
- Address  out  32  word index = {2'b00, addr[31:2]}
- WriteData  out  32  word to be written
- ReadData  in  32  combinational read data, valid in the same cycle as MemRead

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, size, signed, addr and wdata.
  - Error condition: size==11; or size==01 with addr[0]!=0; or size==10 with addr[1:0]!=0. On error -> RESP with resp_error=1.
  - Otherwise, go to the first matching state:
    - load -> LOAD
    - word store -> STORE
    - byte or halfword store -> RMW_RD
- LOAD:
  - MemRead=1, Address driven.
  - At the edge, capture lane-extracted ReadData into resp_rdata. -> RESP.
- Lane extraction is little-endian:
  - Byte k = ReadData[8k+7:8k] with k=addr[1:0].
  - Half = ReadData[16h+15:16h] with h=addr[1].
  - Extended to 32 bits per req_signed.
- RMW_RD:
  - MemRead=1.
  - Capture ReadData into a merge register. -> STORE.
- STORE:
  - MemWrite=1, MemRead=0.
  - Word store: WriteData = wdata.
  - Byte store: WriteData = merge register with lane k replaced by wdata[7:0].
  - Halfword store: WriteData = merge register with half h replaced by wdata[15:0].
  - -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - On resp_ready -> IDLE.
  - req_ready stays 0 until IDLE, so there are no back-to-back acceptances without an IDLE cycle.
- MemRead and MemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- Address and WriteData are 0 whenever their strobe is low.
- Address bits above [7:0] pass through unchanged; the memory ignores them.

## Timing
- Reset values: req_ready=0 while reset is high and 1 after release; all other outputs 0; state IDLE; latched registers 0.
- Reset is asynchronous. Asserting it mid-operation drops MemWrite/MemRead immediately. A STORE cycle interrupted before its edge performs no write. Any pending response is discarded.
- Latency from the acceptance edge to resp_valid first high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- If resp_ready is already high when resp_valid rises, the response lasts exactly one cycle and req_ready returns on the next cycle.
- resp_valid held N cycles under backpressure: outputs are constant and no memory strobes are asserted.
- Stores become visible in memory at the edge ending STORE, before resp_valid rises.

## Test plan
- Word store then load:
  - Stimulus: store word 0xDEADBEEF to addr 0x10, then load word from 0x10.
  - MemWrite pulses one cycle with Address=4 and WriteData=0xDEADBEEF.
  - Load resp_rdata=0xDEADBEEF at 2-cycle latency, resp_error=0.
- Sub-word loads:
  - Preload word 4 with 0x80FF7F01.
  - Load byte signed at 0x13 -> 0xFFFFFF80.
  - Load byte unsigned at 0x13 -> 0x00000080.
  - Load half signed at 0x12 -> 0xFFFF80FF.
  - Load half unsigned at 0x10 -> 0x00007F01.
- Read-modify-write byte store:
  - Preload word 4 with 0x11223344; store byte 0xAA to 0x11.
  - RMW_RD asserts MemRead; STORE writes 0x1122AA44.
  - resp_valid rises 3 cycles after acceptance.
- Error path:
  - Load halfword at 0x11, store word at 0x12, and a request with size=11.
  - Each gives resp_error=1 and resp_rdata=0 after 1 cycle; MemRead and MemWrite never assert.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles after a load.
  - resp_valid and resp_rdata stay stable; req_ready=0 throughout.
  - When resp_ready=1, the unit returns to IDLE on the next edge.
- Reset mid-store:
  - Assert reset asynchronously during STORE, before the edge.
  - MemWrite falls immediately; memory content is unchanged; all outputs are 0.
  - After release, req_ready=1.
